// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller:
// state encodings and the default operand width.
package serial_add_ctrl_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        SA_IDLE = 2'b00,
        SA_RUN  = 2'b01,
        SA_DONE = 2'b10,
        SA_ILL  = 2'b11
    } sa_state_e;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell shared by the serial adder.
// Purely combinational: sum and carry from p, q and carry-in.
module fulladder (
    input  logic p,
    input  logic q,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_pq;

    // Propagate term feeds both the sum and carry paths
    always_comb begin
        w_pq = p ^ q;
        s    = w_pq ^ ci;
        co   = (p & q) | (ci & w_pq);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder, LSB first,
// one bit per clock, one-cycle done pulse on completion.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WIDTH = SA_WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sa_state_e        r_state;
    sa_state_e        w_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic             w_s;
    logic             w_co;

    fulladder U_FA (
        .p  (r_sa[0]),
        .q  (r_sb[0]),
        .ci (r_cy),
        .s  (w_s),
        .co (w_co)
    );

    // State register; reset and the unused encoding land in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SA_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state: start only honoured in IDLE, DONE lasts one cycle
    always_comb begin
        w_nxt = SA_IDLE;
        unique case (r_state)
            SA_IDLE: w_nxt = start ? SA_RUN : SA_IDLE;
            SA_RUN:  w_nxt = (r_cnt == LAST) ? SA_DONE : SA_RUN;
            SA_DONE: w_nxt = SA_IDLE;
            default: w_nxt = SA_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            SA_RUN:  busy = 1'b1;
            SA_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry flop, result shifter and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_cy  <= 1'b0;
        end else begin
            case (r_state)
                SA_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_cy  <= cin;
                        r_res <= '0;
                        r_cnt <= '0;
                    end
                end
                SA_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    r_cy  <= w_co;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result and final carry come straight from the holding registers
    assign sum  = r_res;
    assign cout = r_cy;

endmodule
